// File: rtl/pixel_load_scheduler.sv
// Pixel load scheduler: assembles 3-byte pixel packets from the UART
// receiver, writes accepted pixels to pixel RAM, kicks off inference once
// a full image is loaded, then hands the class index to the transmitter.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// RX0      | waiting for a header byte (byte 0 of a packet)
// RX1      | byte 0 held, waiting for byte 1 (idle timer running)
// RX2      | bytes 0/1 held, waiting for byte 2 (idle timer running)
// START    | full image written, pulsing cpu_start
// WAIT_CPU | inference running, waiting for cpu_halt
// TX       | result byte offered to the transmitter
module pixel_load_scheduler #(
  parameter int NUM_PIXELS     = 784,
  parameter int ADDR_W         = 10,
  parameter int TIMEOUT_CYCLES = 5000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_valid,
  input  logic [7:0]        rx_byte,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              cpu_start,
  input  logic              cpu_halt,
  input  logic [3:0]        nn_result,
  output logic              tx_valid,
  output logic [7:0]        tx_byte,
  input  logic              tx_ready,
  output logic [ADDR_W-1:0] pkt_count,
  output logic [7:0]        err_count,
  output logic              busy
);

  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  // Loading TIMEOUT_CYCLES-1 on each byte makes the terminal count (zero)
  // get hit on exactly the TIMEOUT_CYCLES-th idle edge after that byte.
  localparam logic [TMR_W-1:0]  TMR_LOAD  = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [ADDR_W-1:0] PKT_LAST  = ADDR_W'(NUM_PIXELS - 1);
  localparam logic [10:0]       LOC_LIMIT = 11'(NUM_PIXELS);

  typedef enum logic [2:0] {
    RX0      = 3'd0,
    RX1      = 3'd1,
    RX2      = 3'd2,
    START    = 3'd3,
    WAIT_CPU = 3'd4,
    TX       = 3'd5
  } state_t;

  state_t           state;
  logic [4:0]       b0_loc;   // only the loc bits of byte 0 are needed
  logic [7:0]       b1;
  logic [TMR_W-1:0] idle_cnt;

  logic [9:0] pkt_loc;
  logic [7:0] pkt_data;
  logic [2:0] pkt_footer;
  logic [2:0] exp_footer;
  logic       pkt_ok;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Decode and validate the packet formed by the held bytes and the byte on rx_byte.
  always_comb begin
    pkt_loc    = {b0_loc, b1[7:3]};
    pkt_data   = {b1[2:0], rx_byte[7:3]};
    pkt_footer = rx_byte[2:0];
    exp_footer = {^pkt_data, ^pkt_loc, ^{pkt_data[7:4], pkt_loc[9:5]}};
    pkt_ok     = (pkt_footer == exp_footer) && ({1'b0, pkt_loc} < LOC_LIMIT);
  end

  // Sequencer: packet assembly, RAM write, CPU handoff and result transmit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= RX0;
      b0_loc    <= '0;
      b1        <= '0;
      idle_cnt  <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_start <= 1'b0;
      tx_valid  <= 1'b0;
      tx_byte   <= '0;
      pkt_count <= '0;
      err_count <= '0;
      busy      <= 1'b0;
    end else begin
      mem_we    <= 1'b0;
      cpu_start <= 1'b0;
      case (state)
        RX0: begin
          if (rx_valid) begin
            if (rx_byte[7:5] == 3'b101) begin
              b0_loc   <= rx_byte[4:0];
              idle_cnt <= TMR_LOAD;
              state    <= RX1;
            end else begin
              err_count <= sat_inc(err_count);
            end
          end
        end
        RX1: begin
          if (rx_valid) begin
            b1       <= rx_byte;
            idle_cnt <= TMR_LOAD;
            state    <= RX2;
          end else if (idle_cnt == '0) begin
            err_count <= sat_inc(err_count);
            state     <= RX0;
          end else begin
            idle_cnt <= idle_cnt - TMR_W'(1);
          end
        end
        RX2: begin
          if (rx_valid) begin
            if (pkt_ok) begin
              mem_we    <= 1'b1;
              mem_addr  <= ADDR_W'(pkt_loc);
              mem_wdata <= pkt_data;
              pkt_count <= pkt_count + ADDR_W'(1);
              if (pkt_count == PKT_LAST) begin
                busy  <= 1'b1;
                state <= START;
              end else begin
                state <= RX0;
              end
            end else begin
              err_count <= sat_inc(err_count);
              state     <= RX0;
            end
          end else if (idle_cnt == '0) begin
            err_count <= sat_inc(err_count);
            state     <= RX0;
          end else begin
            idle_cnt <= idle_cnt - TMR_W'(1);
          end
        end
        START: begin
          cpu_start <= 1'b1;
          state     <= WAIT_CPU;
        end
        WAIT_CPU: begin
          // Received bytes are deliberately dropped here without counting.
          if (cpu_halt) begin
            tx_byte  <= {4'b0000, nn_result};
            tx_valid <= 1'b1;
            state    <= TX;
          end
        end
        TX: begin
          if (tx_ready) begin
            tx_valid  <= 1'b0;
            pkt_count <= '0;
            busy      <= 1'b0;
            state     <= RX0;
          end
        end
        default: state <= RX0;
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_load_scheduler.sv
// Self-checking bench for pixel_load_scheduler: directed vector table,
// timeout/full-image/reset sequences, and randomized packet streams
// checked against a byte-stream reference model.
module tb_pixel_load_scheduler;

  localparam int NP = 784;
  localparam int AW = 10;
  localparam int TO = 5000;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          rx_valid = 1'b0;
  logic [7:0]    rx_byte = 8'h00;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata;
  logic          cpu_start;
  logic          cpu_halt = 1'b0;
  logic [3:0]    nn_result = 4'h0;
  logic          tx_valid;
  logic [7:0]    tx_byte;
  logic          tx_ready = 1'b0;
  logic [AW-1:0] pkt_count;
  logic [7:0]    err_count;
  logic          busy;

  pixel_load_scheduler #(.NUM_PIXELS(NP), .ADDR_W(AW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_byte(rx_byte),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_start(cpu_start), .cpu_halt(cpu_halt), .nn_result(nn_result),
    .tx_valid(tx_valid), .tx_byte(tx_byte), .tx_ready(tx_ready),
    .pkt_count(pkt_count), .err_count(err_count), .busy(busy)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model state: partial packet, expected counters, expected writes.
  logic [7:0]  part[$];
  int          exp_err = 0;
  int          exp_pkt = 0;
  logic [17:0] exp_wr[$];

  // Observed DUT activity.
  logic [17:0] got_wr[$];
  int          cyc = 0;
  int          last_we_cyc = 0;
  int          start_cyc = 0;
  int          start_cnt = 0;

  // Monitor: record writes and start pulses away from the active edge.
  always @(negedge clk) begin
    cyc++;
    if (mem_we === 1'b1) begin
      got_wr.push_back({mem_addr, mem_wdata});
      last_we_cyc = cyc;
    end
    if (cpu_start === 1'b1) begin
      start_cnt++;
      start_cyc = cyc;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  function automatic logic [2:0] footer_of(input logic [9:0] loc, input logic [7:0] d);
    return {^d, ^loc, ^{d[7:4], loc[9:5]}};
  endfunction

  function automatic logic pkt_good(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    logic [9:0] loc;
    logic [7:0] d;
    loc = {a[4:0], b[7:3]};
    d   = {b[2:0], c[7:3]};
    return (c[2:0] == footer_of(loc, d)) && (int'(loc) < NP);
  endfunction

  task automatic model_byte(input logic [7:0] b);
    if (part.size() == 0 && b[7:5] != 3'b101) begin
      exp_err = (exp_err < 255) ? exp_err + 1 : 255;
    end else begin
      part.push_back(b);
      if (part.size() == 3) begin
        if (pkt_good(part[0], part[1], part[2])) begin
          exp_pkt++;
          exp_wr.push_back({part[0][4:0], part[1][7:3], part[1][2:0], part[2][7:3]});
        end else begin
          exp_err = (exp_err < 255) ? exp_err + 1 : 255;
        end
        part.delete();
      end
    end
  endtask

  // Called at a negedge; the byte is sampled at the next posedge and the
  // task returns on the following negedge.
  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_byte  = b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_m(input logic [7:0] b);
    model_byte(b);
    send_byte(b);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_pkt(input logic [9:0] loc, input logic [7:0] d, input logic [2:0] fx);
    logic [2:0] f;
    f = footer_of(loc, d) ^ fx;
    send_m({3'b101, loc[9:5]});
    send_m({loc[4:0], d[7:5]});
    send_m({d[4:0], f});
  endtask

  task automatic check_zero(input string name);
    check(name, 32'(|{mem_we, mem_addr, mem_wdata, cpu_start, tx_valid, tx_byte,
                      pkt_count, err_count, busy}), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check_zero("reset_outputs_zero");
    end
    rst = 1'b1;
    @(negedge clk);
    part.delete();
    exp_wr.delete();
    got_wr.delete();
    exp_err = 0;
    exp_pkt = 0;
  endtask

  task automatic load_image();
    for (int l = 0; l < NP; l++) send_pkt(10'(l), 8'($urandom), 3'b000);
  endtask

  task automatic compare_writes(input string name);
    int nmis;
    nmis = 0;
    check({name, "_count"}, 32'(got_wr.size()), 32'(exp_wr.size()));
    for (int i = 0; i < exp_wr.size() && i < got_wr.size(); i++)
      if (got_wr[i] !== exp_wr[i]) nmis++;
    check({name, "_data"}, 32'(nmis), 32'd0);
  endtask

  typedef struct {
    logic [7:0] b0, b1, b2;
    logic       acc;
    logic [9:0] addr;
    logic [7:0] data;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int e_pkt;
    int e_err;
    int w;
    int s0;

    vecs[0] = '{8'hA0, 8'h1C, 8'h09, 1'b1, 10'd3,   8'h81}; // valid loc 3
    vecs[1] = '{8'hA0, 8'h1C, 8'h08, 1'b0, 10'd0,   8'h00}; // footer bit 0 wrong
    vecs[2] = '{8'hA0, 8'h1C, 8'h09, 1'b1, 10'd3,   8'h81}; // accepted after reject
    vecs[3] = '{8'hA0, 8'h1C, 8'h0B, 1'b0, 10'd0,   8'h00}; // footer bit 1 wrong
    vecs[4] = '{8'hB9, 8'h00, 8'h03, 1'b0, 10'd0,   8'h00}; // loc 800, good footer
    vecs[5] = '{8'hB8, 8'h7A, 8'hD0, 1'b1, 10'd783, 8'h5A}; // last legal loc
    vecs[6] = '{8'hB8, 8'h80, 8'h02, 1'b0, 10'd0,   8'h00}; // loc 784, good footer
    vecs[7] = '{8'hA0, 8'h1C, 8'h0D, 1'b0, 10'd0,   8'h00}; // footer bit 2 wrong

    // Reset state
    @(negedge clk);
    do_reset();

    // Directed vector table
    e_pkt = 0;
    e_err = 0;
    foreach (vecs[i]) begin
      send_byte(vecs[i].b0);
      send_byte(vecs[i].b1);
      send_byte(vecs[i].b2);
      check($sformatf("vec%0d_we", i), 32'(mem_we), 32'(vecs[i].acc));
      if (vecs[i].acc) begin
        e_pkt++;
        check($sformatf("vec%0d_addr", i), 32'(mem_addr), 32'(vecs[i].addr));
        check($sformatf("vec%0d_data", i), 32'(mem_wdata), 32'(vecs[i].data));
      end else begin
        e_err++;
      end
      check($sformatf("vec%0d_pkt", i), 32'(pkt_count), 32'(e_pkt));
      check($sformatf("vec%0d_err", i), 32'(err_count), 32'(e_err));
    end
    idle(1);
    check("we_one_cycle", 32'(mem_we), 32'd0);

    // Bad header byte is dropped, then a packet is still accepted from RX0
    send_byte(8'h40);
    check("badhdr_err", 32'(err_count), 32'(e_err + 1));
    check("badhdr_no_we", 32'(mem_we), 32'd0);
    send_byte(8'hA0); send_byte(8'h1C); send_byte(8'h09);
    check("after_badhdr_we", 32'(mem_we), 32'd1);
    check("after_badhdr_pkt", 32'(pkt_count), 32'(e_pkt + 1));

    // Timeout: no error before TIMEOUT_CYCLES idle edges, one error at it
    send_byte(8'hA0); send_byte(8'h1C);
    idle(TO - 1);
    check("timeout_not_early", 32'(err_count), 32'(e_err + 1));
    idle(1);
    check("timeout_err", 32'(err_count), 32'(e_err + 2));
    send_byte(8'hA0); send_byte(8'h1C); send_byte(8'h09);
    check("after_timeout_we", 32'(mem_we), 32'd1);
    check("after_timeout_pkt", 32'(pkt_count), 32'(e_pkt + 2));
    // Byte arriving on idle cycle 4999 is still part of the packet
    send_byte(8'hA0); send_byte(8'h1C);
    idle(TO - 2);
    send_byte(8'h09);
    check("late_byte_we", 32'(mem_we), 32'd1);
    check("late_byte_err", 32'(err_count), 32'(e_err + 2));
    check("late_byte_pkt", 32'(pkt_count), 32'(e_pkt + 3));

    // Randomized packet stream against the reference model
    do_reset();
    for (int n = 0; n < 150; n++) begin
      int kind;
      logic [7:0] rb;
      kind = $urandom_range(0, 9);
      if (kind <= 5) begin
        send_pkt(10'($urandom_range(0, NP - 1)), 8'($urandom), 3'b000);
      end else if (kind == 6) begin
        send_pkt(10'($urandom_range(0, NP - 1)), 8'($urandom), 3'($urandom_range(1, 7)));
      end else if (kind == 7) begin
        send_pkt(10'($urandom_range(NP, 1023)), 8'($urandom), 3'b000);
      end else if (kind == 8) begin
        rb = 8'($urandom);
        if (rb[7:5] == 3'b101) rb[7] = 1'b0;
        send_m(rb);
      end else begin
        repeat (3) send_m(8'($urandom));
      end
      check("rand_pkt", 32'(pkt_count), 32'(exp_pkt));
      check("rand_err", 32'(err_count), 32'(exp_err));
      idle($urandom_range(0, 3));
    end
    idle(2);
    compare_writes("rand_writes");

    // Full image, CPU handoff and result transmit
    do_reset();
    s0 = start_cnt;
    load_image();
    idle(3);
    compare_writes("img_writes");
    check("img_start_once", 32'(start_cnt - s0), 32'd1);
    check("img_start_after_we", 32'(start_cyc - last_we_cyc), 32'd1);
    check("img_busy", 32'(busy), 32'd1);
    check("img_pkt", 32'(pkt_count), 32'(NP));
    send_byte(8'hA0); send_byte(8'h1C); send_byte(8'h09); send_byte(8'h40);
    idle(2);
    check("wait_rx_no_write", 32'(got_wr.size()), 32'(NP));
    check("wait_rx_no_err", 32'(err_count), 32'd0);
    check("wait_no_tx", 32'(tx_valid), 32'd0);
    cpu_halt  = 1'b1;
    nn_result = 4'd7;
    w = 0;
    while (tx_valid !== 1'b1 && w < 20) begin
      @(negedge clk);
      w++;
    end
    check("tx_valid_seen", 32'(tx_valid), 32'd1);
    check("tx_byte", 32'(tx_byte), 32'h07);
    cpu_halt  = 1'b0;
    nn_result = 4'd3;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("tx_hold_byte", 32'(tx_byte), 32'h07);
      check("tx_hold_valid", 32'(tx_valid), 32'd1);
    end
    tx_ready = 1'b1;
    @(negedge clk);
    tx_ready = 1'b0;
    check("tx_done_valid", 32'(tx_valid), 32'd0);
    check("tx_done_pkt", 32'(pkt_count), 32'd0);
    check("tx_done_busy", 32'(busy), 32'd0);
    check("tx_done_start_once", 32'(start_cnt - s0), 32'd1);
    send_byte(8'hA0); send_byte(8'h1C); send_byte(8'h09);
    check("rearm_we", 32'(mem_we), 32'd1);
    check("rearm_pkt", 32'(pkt_count), 32'd1);

    // Reset mid-packet: held bytes are discarded
    do_reset();
    send_byte(8'hA0); send_byte(8'h1C);
    do_reset();
    send_byte(8'h09);
    check("rst_pkt_drop_we", 32'(mem_we), 32'd0);
    check("rst_pkt_drop_err", 32'(err_count), 32'd1);
    check("rst_pkt_drop_pkt", 32'(pkt_count), 32'd0);

    // Reset during WAIT_CPU: no stale pulse, next image starts from zero
    do_reset();
    load_image();
    idle(4);
    check("rst_wait_busy_before", 32'(busy), 32'd1);
    s0 = start_cnt;
    do_reset();
    idle(3);
    check("rst_wait_no_start", 32'(start_cnt - s0), 32'd0);
    check("rst_wait_no_write", 32'(got_wr.size()), 32'd0);
    send_byte(8'hA0); send_byte(8'h1C); send_byte(8'h09);
    check("rst_wait_reload_pkt", 32'(pkt_count), 32'd1);
    check("rst_wait_reload_addr", 32'(mem_addr), 32'd3);

    // err_count saturates
    do_reset();
    repeat (260) send_byte(8'h40);
    check("err_saturate", 32'(err_count), 32'hFF);
    send_byte(8'hA0); send_byte(8'h1C); send_byte(8'h08);
    check("err_saturate_hold", 32'(err_count), 32'hFF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pixel_load_scheduler.md
Name: pixel_load_scheduler

Overview:
- Sits between the UART receiver, the pixel memory, the CPU/NN core and the UART transmitter.
- Assembles 3-byte pixel packets, validates header and footer, and writes accepted pixels to pixel RAM.
- Once NUM_PIXELS packets are accepted, starts the CPU and waits for halt.
- Hands the 4-bit classification to the transmitter, then re-arms for the next image.

Parameters:
- NUM_PIXELS, 784, accepted packets required before the CPU is started.
- ADDR_W, 10, pixel address width; must satisfy 2^ADDR_W >= NUM_PIXELS.
- TIMEOUT_CYCLES, 5000, max clk cycles allowed between bytes of one packet.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- rx_valid  in  1  one-cycle strobe: rx_byte holds a received byte.
- rx_byte  in  8  received byte.
- mem_we  out  1  pixel RAM write strobe.
- mem_addr  out  ADDR_W  pixel RAM address.
- mem_wdata  out  8  pixel RAM data.
- cpu_start  out  1  one-cycle pulse that starts inference.
- cpu_halt  in  1  level: CPU has finished.
- nn_result  in  4  class index, valid while cpu_halt=1.
- tx_valid  out  1  result byte available.
- tx_byte  out  8  {4'b0000, result}.
- tx_ready  in  1  transmitter accepts tx_byte when tx_valid and tx_ready are both high.
- pkt_count  out  ADDR_W  accepted packets for the current image.
- err_count  out  8  rejected packets/bytes, saturates at 255.
- busy  out  1  high in the CPU and TX states.

Behaviour:
- Packet format, 24 bits sent MSB byte first: [23:21] header=3'b101, [20:11] loc, [10:3] data, [2:0] footer.
- Footer rules:
  - f[2] = ^data.
  - f[1] = ^loc.
  - f[0] = ^{data[7:4], loc[9:5]}.
- Reset (rst=0): state=RX0; all outputs 0; counters 0; byte registers 0. Reset may arrive in any state; the block restarts cleanly from RX0 with no stale write or pulse.
- State RX0:
  - On rx_valid with rx_byte[7:5]==3'b101: store as b0, go to RX1.
  - On rx_valid with a bad header: drop the byte, err_count+1, stay in RX0.
- State RX1: on rx_valid, store b1, go to RX2.
- State RX2: on rx_valid, evaluate the packet {b0, b1, rx_byte} in that same cycle.
  - Packet is accepted only if the footer matches AND loc < NUM_PIXELS.
  - Accepted: mem_we=1 for exactly one cycle, registered, in the cycle after the strobe, with mem_addr=loc and mem_wdata=data. pkt_count increments in that same cycle.
    - If the new pkt_count equals NUM_PIXELS, go to START; otherwise go to RX0.
  - Rejected: no write, err_count+1, go to RX0.
- Timeout in RX1/RX2:
  - An idle counter resets on every rx_valid.
  - When it reaches TIMEOUT_CYCLES: discard the partial packet, err_count+1, return to RX0.
  - If rx_valid and the timeout occur in the same cycle, the byte wins and no timeout is taken.
- START: cpu_start=1 for one cycle, which is the cycle after the final mem_we. busy=1. Go to WAIT_CPU.
- WAIT_CPU:
  - rx_valid is ignored; bytes are dropped and not counted as errors.
  - When cpu_halt is sampled high, latch nn_result and go to TX.
  - cpu_halt already high on entry is accepted in the first WAIT_CPU cycle.
- TX:
  - tx_valid=1; tx_byte is held stable until tx_valid and tx_ready are both high.
  - On that handshake cycle:
    - tx_valid drops on the next edge.
    - pkt_count clears to 0; err_count holds its value.
    - busy drops; go to RX0.
- Duplicate locations are not tracked: every accepted packet counts. The sender guarantees unique loc values per image.
- Counter widths:
  - pkt_count never exceeds NUM_PIXELS.
  - err_count saturates at 8'hFF; it does not wrap.

Test Plan:
- Valid packet: bytes A0,1C,09 (loc=3, data=0x81, footer=001) -> one mem_we one cycle after the 3rd strobe, addr=3, data=0x81; pkt_count=1; err_count=0.
- Bad footer: bytes A0,1C,08 -> no mem_we; err_count=1; the following A0,1C,09 is accepted normally.
- Bad header and out-of-range loc:
  - Byte 0x40 in RX0 -> dropped, err_count+1, state stays RX0.
  - Packet with loc=800 (valid footer) -> rejected, no write.
- Timeout: send A0,1C then idle 5000 cycles -> state returns to RX0 and err_count+1; a following full valid packet is accepted. A byte arriving on cycle 4999 is accepted with no timeout.
- Full image:
  - 784 valid packets, loc 0..783 -> 784 writes; cpu_start pulses exactly once, one cycle after the last write.
  - Extra RX bytes during WAIT_CPU are ignored.
  - Drive cpu_halt with nn_result=7 -> tx_valid with tx_byte=0x07. Hold tx_ready=0 for 10 cycles: tx_byte stays stable. Then tx_ready=1 -> tx_valid drops, pkt_count=0, state RX0.
- Reset mid-packet and mid-WAIT_CPU: assert rst=0 for 3 cycles -> all outputs 0, no cpu_start, no mem_we; the next image loads from pkt_count=0.
